// File: rtl/img_proc_pkg.sv
// Shared image-processing definitions for the 3x3 window generator, the
// median filter and the sorting network.
//   DATA_W_DEF    : default pixel width
//   IMG_WIDTH_DEF : default active pixels per line
//   ADDR_W_DEF    : default column counter width
//   pixel_t       : pixel type at the default width
package img_proc_pkg;
    localparam int DATA_W_DEF    = 8;
    localparam int IMG_WIDTH_DEF = 640;
    localparam int ADDR_W_DEF    = 10;

    typedef logic [DATA_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/line_buf_ram.sv
// Single-port read-before-write line buffer.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : asynchronous read of mem[addr]; shows the old word in the write cycle
module line_buf_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: stale contents are masked downstream by the line counter.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/matrix_3x3_gen.sv
// Builds a 3x3 pixel neighbourhood from a raster stream for the median filter.
//   clk, rst_n                 : pixel clock, async active-low reset
//   per_frame_vsync/href/clken : input frame sync, line valid, pixel strobe
//   per_img_data               : input pixel
//   matrix_frame_vsync/href/clken : input syncs delayed 2 cycles
//   data11..data13             : window row from line r-2, left to right
//   data21..data23             : window row from line r-1
//   data31..data33             : window row from current line r
module matrix_3x3_gen
    import img_proc_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_data,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] data11, data12, data13,
    output logic [DATA_W-1:0] data21, data22, data23,
    output logic [DATA_W-1:0] data31, data32, data33
);
    logic [1:0]        vsync_d, href_d, clken_d;
    logic [ADDR_W-1:0] col_cnt;
    logic [1:0]        line_cnt;
    logic [DATA_W-1:0] old_a, old_b;
    logic [2:0][DATA_W-1:0]      row_d;   // [0]=row1 (r-2) .. [2]=row3 (r)
    logic [2:0][2:0][DATA_W-1:0] win;     // [row][col], col 0 is leftmost

    logic vsync_rise, href_fall, href_d1_rise;
    assign vsync_rise   = per_frame_vsync & ~vsync_d[0];
    assign href_fall    = ~per_frame_href & href_d[0];
    assign href_d1_rise = href_d[0] & ~href_d[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= '0;
            href_d  <= '0;
            clken_d <= '0;
        end else begin
            vsync_d <= {vsync_d[0], per_frame_vsync};
            href_d  <= {href_d[0],  per_frame_href};
            clken_d <= {clken_d[0], per_frame_clken};
        end
    end

    // vsync rising takes priority so a coincident href fall clears both counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            line_cnt <= '0;
        end else if (vsync_rise) begin
            col_cnt  <= '0;
            line_cnt <= '0;
        end else if (href_fall) begin
            col_cnt  <= '0;
            if (line_cnt != 2'd2) line_cnt <= line_cnt + 2'd1;
        end else if (per_frame_clken) begin
            // Overlong lines wrap onto address 0 rather than running off the RAM.
            if (col_cnt == ADDR_W'(IMG_WIDTH - 1)) col_cnt <= '0;
            else                                   col_cnt <= col_cnt + 1'b1;
        end
    end

    // buf_a holds line r-1; its old word cascades into buf_b (line r-2).
    line_buf_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_a (
        .clk(clk), .we(per_frame_clken), .addr(col_cnt),
        .wdata(per_img_data), .rdata(old_a)
    );

    line_buf_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_b (
        .clk(clk), .we(per_frame_clken), .addr(col_cnt),
        .wdata(old_a), .rdata(old_b)
    );

    // Rows above the top border read 0 until enough lines have been stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_d <= '0;
        end else begin
            row_d[2] <= per_img_data;
            row_d[1] <= (line_cnt >= 2'd1) ? old_a : '0;
            row_d[0] <= (line_cnt == 2'd2) ? old_b : '0;
        end
    end

    // Start of a line zero-fills the left taps; a pixel arriving in the same
    // cycle still shifts in so the first column is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (clken_d[0]) begin
            for (int x = 0; x < 3; x++) begin
                win[x][0] <= href_d1_rise ? '0 : win[x][1];
                win[x][1] <= href_d1_rise ? '0 : win[x][2];
                win[x][2] <= row_d[x];
            end
        end else if (href_d1_rise) begin
            win <= '0;
        end
    end

    assign matrix_frame_vsync = vsync_d[1];
    assign matrix_frame_href  = href_d[1];
    assign matrix_frame_clken = clken_d[1];

    assign data11 = win[0][0];
    assign data12 = win[0][1];
    assign data13 = win[0][2];
    assign data21 = win[1][0];
    assign data22 = win[1][1];
    assign data23 = win[1][2];
    assign data31 = win[2][0];
    assign data32 = win[2][1];
    assign data33 = win[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen on a 4-pixel-wide image.
module tb_matrix_3x3_gen;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] pix = 8'd0;
    logic       o_vs, o_hr, o_ck;
    logic [7:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;

    int checks = 0;
    int failures = 0;

    matrix_3x3_gen #(.IMG_WIDTH(W), .DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_data(pix),
        .matrix_frame_vsync(o_vs), .matrix_frame_href(o_hr),
        .matrix_frame_clken(o_ck),
        .data11(d11), .data12(d12), .data13(d13),
        .data21(d21), .data22(d22), .data23(d23),
        .data31(d31), .data32(d32), .data33(d33)
    );

    always #5 clk = ~clk;

    // Reference model: line contents by column, line counter, per-line tap history.
    int  m1 [W];
    int  m2 [W];
    int  lc;
    int  r1q[$], r2q[$], r3q[$];
    logic [71:0] expq[$];
    logic [2:0]  h0, h1;

    function automatic int tap(input int q[$], input int idx);
        return (idx < 0) ? 0 : q[idx];
    endfunction

    function automatic logic [71:0] window_now();
        logic [71:0] w;
        int k;
        k = r3q.size() - 1;
        w = '0;
        for (int j = 0; j < 3; j++) begin
            w[71-8*j -: 8] = 8'(tap(r1q, k-2+j));
            w[47-8*j -: 8] = 8'(tap(r2q, k-2+j));
            w[23-8*j -: 8] = 8'(tap(r3q, k-2+j));
        end
        return w;
    endfunction

    function automatic logic [71:0] got_window();
        return {d11, d12, d13, d21, d22, d23, d31, d32, d33};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives one pixel and queues its expected window; hand values override.
    task automatic send_pixel(input int r, input int k, input logic [71:0] hand, input bit use_hand);
        int p, col, a, b;
        p   = 16*r + k + 1;
        col = k % W;
        a   = m1[col];
        b   = m2[col];
        r3q.push_back(p);
        r2q.push_back((lc >= 1) ? a : 0);
        r1q.push_back((lc == 2) ? b : 0);
        m2[col] = a;
        m1[col] = p;
        expq.push_back(use_hand ? hand : window_now());
        clken = 1'b1;
        pix   = 8'(p);
        tick();
    endtask

    task automatic end_line();
        href  = 1'b0;
        clken = 1'b0;
        pix   = 8'd0;
        if (lc < 2) lc++;
        r1q.delete(); r2q.delete(); r3q.delete();
        repeat (3) tick();
    endtask

    task automatic send_line(input int r, input int n);
        href = 1'b1;
        for (int k = 0; k < n; k++) begin
            if      (r == 0 && k == 2 && n == W) send_pixel(r, k, 72'h000000_000000_010203, 1'b1);
            else if (r == 1 && k == 1)           send_pixel(r, k, 72'h000000_000102_001112, 1'b1);
            else if (r == 2 && k == 2)           send_pixel(r, k, 72'h010203_111213_212223, 1'b1);
            else                                 send_pixel(r, k, '0, 1'b0);
        end
        end_line();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        lc    = 0;
        repeat (2) tick();
    endtask

    task automatic frame_end();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_zero_outputs(input string name);
        logic [74:0] got;
        got = {o_vs, o_hr, o_ck, got_window()};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL %s: got %h required 0", name, got);
        end
    endtask

    // Sync latency: outputs must equal the inputs captured two edges earlier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = '0;
            h1 = '0;
        end else begin
            h1 = h0;
            h0 = {vsync, href, clken};
        end
    end

    // Monitor: checks sync alignment every cycle and pops a window per output clken.
    always @(negedge clk) begin
        logic [71:0] e;
        if (rst_n) begin
            checks++;
            if ({o_vs, o_hr, o_ck} !== h1) begin
                failures++;
                $display("FAIL sync_delay @%0t: got %b required %b", $time, {o_vs, o_hr, o_ck}, h1);
            end
            if (o_ck) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL window_unexpected @%0t: got %h required no output", $time, got_window());
                end else begin
                    e = expq.pop_front();
                    if (got_window() !== e) begin
                        failures++;
                        $display("FAIL window @%0t: got %h required %h", $time, got_window(), e);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < W; i++) begin m1[i] = 0; m2[i] = 0; end
        lc = 0;
        #12;
        check_zero_outputs("reset_state");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Full 3-line frame: top border, second line, interior.
        frame_start();
        for (int r = 0; r < 3; r++) send_line(r, W);
        frame_end();

        // Overlong first line: fifth pixel overwrites column 0.
        frame_start();
        href = 1'b1;
        for (int k = 0; k < 5; k++) send_pixel(0, k, '0, 1'b0);
        end_line();
        checks++;
        if (dut.col_cnt !== 2'd0) begin
            failures++;
            $display("FAIL wrap_col_cnt: got %0d required 0", dut.col_cnt);
        end
        href = 1'b1;
        send_pixel(1, 0, 72'h000000_000005_000011, 1'b1);
        for (int k = 1; k < W; k++) send_pixel(1, k, '0, 1'b0);
        end_line();
        frame_end();

        // Reset in the middle of line 2.
        frame_start();
        send_line(0, W);
        send_line(1, W);
        href = 1'b1;
        send_pixel(2, 0, '0, 1'b0);
        send_pixel(2, 1, '0, 1'b0);
        rst_n = 1'b0;
        expq.delete();
        r1q.delete(); r2q.delete(); r3q.delete();
        vsync = 1'b0; href = 1'b0; clken = 1'b0; pix = 8'd0;
        #1;
        check_zero_outputs("reset_mid_frame");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Next frame after reset: stale RAM must be masked on line 0.
        frame_start();
        send_line(0, W);
        send_line(1, W);
        frame_end();

        repeat (4) tick();
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_3x3_gen.md
Name: matrix_3x3_gen

Overview:
- Upstream neighbour of the 3x3 median filter.
- Converts a raster pixel stream (vsync/href/clken + 8-bit pixel) into a 3x3 neighbourhood data11..data33.
- Uses two line buffers and per-row 3-tap shift registers.
- Delays frame sync/valid signals so they line up with the window; these outputs drive the median filter's median_frame_* inputs directly.

Parameters:
- IMG_WIDTH, 640, active pixels per line; line buffer depth.
- DATA_W, 8, pixel width.
- ADDR_W, 10, column counter width; must satisfy 2^ADDR_W >= IMG_WIDTH.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- per_frame_vsync  in  1  frame sync, high during frame.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel valid strobe.
- per_img_data  in  DATA_W  input pixel, valid when clken=1.
- matrix_frame_vsync  out  1  vsync delayed 2 cycles.
- matrix_frame_href  out  1  href delayed 2 cycles.
- matrix_frame_clken  out  1  clken delayed 2 cycles.
- data11,data12,data13  out  DATA_W  window row 1 (line r-2), left to right.
- data21,data22,data23  out  DATA_W  window row 2 (line r-1).
- data31,data32,data33  out  DATA_W  window row 3 (line r, current).

Behaviour:
- Reset: all outputs 0, all counters 0, shift registers 0. Line RAM contents are not reset; masking by line_cnt covers stale data.
- col_cnt (ADDR_W):
  - Cleared on href falling edge and on vsync rising edge.
  - +1 on each clken.
  - Wraps from IMG_WIDTH-1 to 0, so extra pixels overwrite address 0 onward and nothing hangs.
- line_cnt (2b):
  - Cleared on vsync rising edge.
  - +1 on href falling edge, saturating at 2.
- Line buffers: two read-before-write RAMs buf_a (line r-1) and buf_b (line r-2), both addressed by col_cnt. On clken, in one cycle:
  - old_a = buf_a[col], old_b = buf_b[col].
  - buf_b[col] <= old_a.
  - buf_a[col] <= per_img_data.
- Stage 1 (registered, cycle t+1 after clken at t):
  - row3_d = pixel.
  - row2_d = (line_cnt>=1) ? old_a : 0.
  - row1_d = (line_cnt==2) ? old_b : 0.
  - clken_d1 = clken.
- Stage 2 (cycle t+2), only when clken_d1=1:
  - dataX1 <= dataX2, dataX2 <= dataX3, dataX3 <= rowX_d, for X = 1, 2, 3.
  - All nine window regs cleared on href_d1 rising edge (left border zero-fill).
  - Window regs hold when clken_d1=0.
- Window alignment: when the output clken corresponds to input pixel (r,c):
  - data33 = pixel(r,c), data22 = pixel(r-1,c-1).
  - Out-of-frame taps read 0.
  - The consumer accepts the one-row, one-column centre offset.
- Sync: vsync/href/clken each pass through a 2-stage shift register. Total latency 2 cycles, fixed, independent of image content.
- Simultaneous events: an href falling edge coinciding with vsync rising resolves as vsync rising (both counters cleared).
- clken while href=0 is still processed (writes at col_cnt); upstream must not do this.
- Reset mid-frame: output returns immediately to 0. The next frame starts from line_cnt=0, so its first two lines are masked.

Decomposition:
- Shared package img_proc_pkg: DATA_W, IMG_WIDTH, ADDR_W defaults, and the pixel_t typedef, shared with median_filter_3x3 and sort_3.
- One sub-module, line_buf_ram: single-port read-before-write RAM (DEPTH, DATA_W), instantiated twice. Synthesisable to block RAM with registered address or to distributed RAM.

Test Plan (IMG_WIDTH=4, ADDR_W=2, pixel(r,c)=16r+c+1, clken continuous within href, 3 lines):
- Latency: clken rises at cycle t -> matrix_frame_clken rises at t+2; vsync/href edges likewise shifted exactly 2 cycles.
- Top border, input (0,2)=3 -> window row1 = 0,0,0; row2 = 0,0,0; row3 = 1,2,3.
- Second line, input (1,1)=18 -> row1 = 0,0,0; row2 = 0,1,2; row3 = 0,17,18 (left taps zero from href clear).
- Interior, input (2,2)=35 -> row1 = 1,2,3; row2 = 17,18,19; row3 = 33,34,35.
- Wrap: line 0 sent with 5 clken (values 1..5) -> 5th writes address 0. In line 1 at col 0, data23 = 5, not 1; no lock-up, col_cnt = 0 after href fall.
- Reset during line 2: all outputs 0 within the async reset. The next frame's line 0 yields rows 1 and 2 all zero despite stale RAM.
